branch_redirect_ctrl: RTL and testbench

- Sequences front-end control of the 5-stage pipeline after the EX-stage branch unit resolves a branch.
- Captures a taken branch target and drives PC select/write to redirect fetch.
- Flushes wrong-path instructions from IF/ID and ID/EX, and inserts load-use bubbles.
- Keeps a saturating count of taken redirects for debug.

---
 rtl/branch_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_branch_redirect_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: front-end redirect, flush and load-use stall sequencing after an EX-stage branch.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   br_i            branch taken, from the EX-stage branch unit
//   br_pc_i         resolved branch target
//   ex_valid_i      EX stage holds a valid instruction
//   load_use_i      decode detected a load-use hazard
//   imem_ready_i    fetch can accept a new PC this cycle
//   pc_sel_o        1 selects redirect_pc_o as next PC, 0 selects PC+4
//   pc_wr_en_o      PC register write enable
//   redirect_pc_o   registered branch target
//   flush_ifid_o    clear IF/ID to a bubble
//   flush_idex_o    clear ID/EX to a bubble
//   stall_id_o      hold IF/ID
//   busy_o          controller not idle
//   br_count_o      saturating count of accepted redirects
module branch_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic              ex_valid_i,
    input  logic              load_use_i,
    input  logic              imem_ready_i,
    output logic              pc_sel_o,
    output logic              pc_wr_en_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              stall_id_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  br_count_o
);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    localparam logic [1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 2'(DRAIN_CYCLES - 1) : 2'd0;

    state_t            state_q, state_d;
    logic [1:0]        drain_q, drain_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  br_count_q, br_count_d;
    logic              take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            drain_q       <= '0;
            redirect_pc_q <= '0;
            br_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            redirect_pc_q <= redirect_pc_d;
            br_count_q    <= br_count_d;
        end
    end

    // Combinational decode is gated by rst so every output sits at its
    // quiet value while reset is held, whatever the inputs are doing.
    assign take = ~rst & (state_q == IDLE) & br_i & ex_valid_i;

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        redirect_pc_d = redirect_pc_q;
        br_count_d    = br_count_q;
        pc_sel_o      = 1'b0;
        pc_wr_en_o    = 1'b0;
        flush_ifid_o  = 1'b0;
        flush_idex_o  = 1'b0;
        stall_id_o    = 1'b0;
        busy_o        = 1'b0;
        case (state_q)
            IDLE: begin
                // A branch outranks a load-use hazard: the stalled instruction is wrong-path anyway.
                stall_id_o   = ~rst & load_use_i & ~take;
                flush_ifid_o = take;
                flush_idex_o = take | stall_id_o;
                pc_wr_en_o   = ~rst & ~take & ~stall_id_o;
                if (take) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = br_pc_i;
                    br_count_d    = &br_count_q ? br_count_q : br_count_q + 1'b1;
                end
            end
            REDIRECT: begin
                pc_sel_o     = 1'b1;
                pc_wr_en_o   = imem_ready_i;
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
                busy_o       = 1'b1;
                if (imem_ready_i) begin
                    state_d = (DRAIN_CYCLES > 0) ? DRAIN : IDLE;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                pc_wr_en_o   = 1'b1;
                flush_ifid_o = 1'b1;
                busy_o       = 1'b1;
                if (drain_q == 2'd0) state_d = IDLE;
                else drain_d = drain_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign redirect_pc_o = redirect_pc_q;
    assign br_count_o    = br_count_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vectors with a queued scoreboard for branch_redirect_ctrl.
module tb_branch_redirect_ctrl;
    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [31:0] rpc;
        logic        fif;
        logic        fie;
        logic        st;
        logic        busy;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic [31:0] br_pc = '0;
    logic        ex_valid = 1'b0;
    logic        load_use = 1'b0;
    logic        imem_ready = 1'b0;
    logic        pc_sel, pc_wr_en, flush_ifid, flush_idex, stall_id, busy;
    logic [31:0] redirect_pc;
    logic [3:0]  br_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   row = 0;

    branch_redirect_ctrl #(.ADDR_W(32), .DRAIN_CYCLES(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .br_i(br), .br_pc_i(br_pc), .ex_valid_i(ex_valid),
        .load_use_i(load_use), .imem_ready_i(imem_ready), .pc_sel_o(pc_sel),
        .pc_wr_en_o(pc_wr_en), .redirect_pc_o(redirect_pc), .flush_ifid_o(flush_ifid),
        .flush_idex_o(flush_idex), .stall_id_o(stall_id), .busy_o(busy), .br_count_o(br_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", r, name, act, want);
        end
    endtask

    // Inputs change 1 ns after the rising edge; expectation is for that same cycle.
    task automatic step(input logic r, input logic b, input logic [31:0] pc, input logic ev,
                        input logic lu, input logic ir, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; br = b; br_pc = pc; ex_valid = ev; load_use = lu; imem_ready = ir;
        exp_q.push_back(e);
    endtask

    function automatic exp_t mk(input logic sel, input logic wr, input logic [31:0] rpc, input logic fif,
                                input logic fie, input logic st, input logic bsy, input logic [3:0] cnt);
        return '{sel: sel, wr: wr, rpc: rpc, fif: fif, fie: fie, st: st, busy: bsy, cnt: cnt};
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                row++;
                chk("pc_sel", row, 32'(pc_sel), 32'(e.sel));
                chk("pc_wr_en", row, 32'(pc_wr_en), 32'(e.wr));
                chk("redirect_pc", row, redirect_pc, e.rpc);
                chk("flush_ifid", row, 32'(flush_ifid), 32'(e.fif));
                chk("flush_idex", row, 32'(flush_idex), 32'(e.fie));
                chk("stall_id", row, 32'(stall_id), 32'(e.st));
                chk("busy", row, 32'(busy), 32'(e.busy));
                chk("br_count", row, 32'(br_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [31:0] last_pc;
        int          wait_cycles;
        // reset held with active-looking inputs: everything quiet
        step(1, 1, 32'hdead, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));
        // basic taken branch to 0x40
        step(0, 1, 32'h40, 1, 0, 1, mk(0, 0, 0, 1, 1, 0, 0, 0));
        step(0, 0, 0, 0, 0, 1, mk(1, 1, 32'h40, 1, 1, 0, 1, 1));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h40, 1, 0, 0, 1, 1));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h40, 0, 0, 0, 0, 1));
        // fetch backpressure, branch to 0x100
        step(0, 1, 32'h100, 1, 0, 0, mk(0, 0, 32'h40, 1, 1, 0, 0, 1));
        step(0, 0, 0, 0, 0, 0, mk(1, 0, 32'h100, 1, 1, 0, 1, 2));
        step(0, 0, 0, 0, 0, 0, mk(1, 0, 32'h100, 1, 1, 0, 1, 2));
        step(0, 0, 0, 0, 0, 0, mk(1, 0, 32'h100, 1, 1, 0, 1, 2));
        step(0, 0, 0, 0, 0, 1, mk(1, 1, 32'h100, 1, 1, 0, 1, 2));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h100, 1, 0, 0, 1, 2));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h100, 0, 0, 0, 0, 2));
        // load-use alone, then together with a branch to 0x80
        step(0, 0, 0, 0, 1, 1, mk(0, 0, 32'h100, 0, 1, 1, 0, 2));
        step(0, 1, 32'h80, 1, 1, 1, mk(0, 0, 32'h100, 1, 1, 0, 0, 2));
        // wrong-path branches in REDIRECT and DRAIN are ignored
        step(0, 1, 32'h200, 1, 0, 1, mk(1, 1, 32'h80, 1, 1, 0, 1, 3));
        step(0, 1, 32'h200, 1, 1, 1, mk(0, 1, 32'h80, 1, 0, 0, 1, 3));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h80, 0, 0, 0, 0, 3));
        // br without ex_valid
        step(0, 1, 32'h300, 0, 0, 1, mk(0, 1, 32'h80, 0, 0, 0, 0, 3));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h80, 0, 0, 0, 0, 3));
        // async reset mid-REDIRECT, asserted between clock edges
        step(0, 1, 32'h400, 1, 0, 0, mk(0, 0, 32'h80, 1, 1, 0, 0, 3));
        step(0, 0, 0, 0, 0, 0, mk(1, 0, 32'h400, 1, 1, 0, 1, 4));
        step(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 0));
        // 16 branches: count saturates at 15, target still captured
        last_pc = 0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] npc;
            logic [3:0]  c0, c1;
            npc = 32'h1000 + 32'(i * 4);
            c0  = (i > 15) ? 4'd15 : 4'(i);
            c1  = (i >= 15) ? 4'd15 : 4'(i + 1);
            step(0, 1, npc, 1, 0, 1, mk(0, 0, last_pc, 1, 1, 0, 0, c0));
            step(0, 0, 0, 0, 0, 1, mk(1, 1, npc, 1, 1, 0, 1, c1));
            step(0, 0, 0, 0, 0, 1, mk(0, 1, npc, 1, 0, 0, 1, c1));
            last_pc = npc;
        end
        step(0, 0, 0, 0, 0, 1, mk(0, 1, 32'h103c, 0, 0, 0, 0, 15));
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
